// File: rtl/branch_redirect_pkg.sv
// Shared widths, branch opcode encoding and redirect bus layout for the
// execute-stage branch resolution unit.
package branch_redirect_pkg;

    localparam int unsigned RegW  = 32;
    localparam int unsigned BrOpW = 4;

    localparam logic [RegW-1:0] LoongPcStartAddr = 32'h1c00_0000;

    // Branch opcodes; codes 10..15 are treated as BrNone.
    localparam logic [BrOpW-1:0] BrNone = 4'd0;
    localparam logic [BrOpW-1:0] BrBeq  = 4'd1;
    localparam logic [BrOpW-1:0] BrBne  = 4'd2;
    localparam logic [BrOpW-1:0] BrBlt  = 4'd3;
    localparam logic [BrOpW-1:0] BrBge  = 4'd4;
    localparam logic [BrOpW-1:0] BrBltu = 4'd5;
    localparam logic [BrOpW-1:0] BrBgeu = 4'd6;
    localparam logic [BrOpW-1:0] BrB    = 4'd7;
    localparam logic [BrOpW-1:0] BrBl   = 4'd8;
    localparam logic [BrOpW-1:0] BrJirl = 4'd9;

    typedef enum logic [0:0] {
        StIdle,
        StPending
    } redir_state_e;

    typedef struct packed {
        logic            taken;
        logic [RegW-1:0] target;
    } jbr_bus_t;

    function automatic logic is_br_op(logic [BrOpW-1:0] op);
        return (op >= BrBeq) && (op <= BrJirl);
    endfunction

    function automatic logic is_link_op(logic [BrOpW-1:0] op);
        return (op == BrBl) || (op == BrJirl);
    endfunction

endpackage

// File: rtl/branch_redirect_br_cond.sv
// Purely combinational LoongArch branch condition evaluator; shared with the
// predictor-check logic.
module branch_redirect_br_cond
    import branch_redirect_pkg::*;
(
    input  logic [BrOpW-1:0] op_i,
    input  logic [RegW-1:0]  rj_i,
    input  logic [RegW-1:0]  rd_i,
    output logic             cond_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rj_i == rd_i);
    assign lt_s = ($signed(rj_i) < $signed(rd_i));
    assign lt_u = (rj_i < rd_i);

    always_comb begin
        cond_o = 1'b0;
        case (op_i)
            BrBeq:  cond_o = eq;
            BrBne:  cond_o = ~eq;
            BrBlt:  cond_o = lt_s;
            BrBge:  cond_o = ~lt_s;
            BrBltu: cond_o = lt_u;
            BrBgeu: cond_o = ~lt_u;
            BrB,
            BrBl,
            BrJirl: cond_o = 1'b1;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect.sv
// Execute-stage branch resolution: evaluates the condition, registers a pending
// redirect on jbr_bus_o until fetch consumes it, and flushes younger stages.
module branch_redirect
    import branch_redirect_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ex_valid_i,
    input  logic [BrOpW-1:0] ex_br_op_i,
    input  logic [RegW-1:0]  ex_pc_i,
    input  logic [RegW-1:0]  ex_rj_i,
    input  logic [RegW-1:0]  ex_rd_i,
    input  logic [RegW-1:0]  ex_offs_i,
    input  logic             ctl_if_allow_nxt_pc_i,
    output logic [RegW:0]    jbr_bus_o,
    output logic [RegW-1:0]  ex_link_o,
    output logic             ex_link_we_o,
    output logic             ex_br_busy_o,
    output logic             ex_flush_o,
    output logic             ex_ade_o
);

    redir_state_e    state_q, state_d;
    logic [RegW-1:0] tgt_q, tgt_d;
    logic            ade_q, ade_d;

    logic            cond;
    logic            fire;
    logic            pending;
    logic            aligned;
    logic [RegW-1:0] tgt_base;
    logic [RegW-1:0] tgt;
    jbr_bus_t        bus;

    branch_redirect_br_cond u_br_cond (
        .op_i   (ex_br_op_i),
        .rj_i   (ex_rj_i),
        .rd_i   (ex_rd_i),
        .cond_o (cond)
    );

    // Carry out of the add is intentionally dropped: targets wrap mod 2^32.
    assign tgt_base = (ex_br_op_i == BrJirl) ? ex_rj_i : ex_pc_i;
    assign tgt      = tgt_base + ex_offs_i;
    assign aligned  = (tgt[1:0] == 2'b00);

    assign pending      = (state_q == StPending);
    assign ex_br_busy_o = pending & ~ctl_if_allow_nxt_pc_i;
    assign ex_flush_o   = pending & ctl_if_allow_nxt_pc_i;
    assign fire         = ex_valid_i & cond & ~ex_br_busy_o;

    assign ex_link_o    = ex_pc_i + 32'd4;
    assign ex_link_we_o = ex_valid_i & is_link_op(ex_br_op_i);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        ade_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (fire) begin
                    if (aligned) begin
                        tgt_d   = tgt;
                        state_d = StPending;
                    end else begin
                        ade_d = 1'b1;
                    end
                end
            end
            StPending: begin
                // Consumption and a new fire on the same edge chain back-to-back.
                if (ctl_if_allow_nxt_pc_i) begin
                    state_d = StIdle;
                    if (fire) begin
                        if (aligned) begin
                            tgt_d   = tgt;
                            state_d = StPending;
                        end else begin
                            ade_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            tgt_q   <= '0;
            ade_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            ade_q   <= ade_d;
        end
    end

    always_comb begin
        bus.taken  = pending;
        bus.target = pending ? tgt_q : '0;
    end

    assign jbr_bus_o = bus;
    assign ex_ade_o  = ade_q;

`ifndef SYNTHESIS
    // A branch in EX while busy is a pipeline protocol violation; it is dropped.
    br_while_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        !(ex_valid_i && ex_br_busy_o && is_br_op(ex_br_op_i)))
        else $warning("branch presented in EX while redirect busy; ignored");

    busy_holds_tgt: assert property (@(posedge clk_i) disable iff (rst_i)
        ex_br_busy_o |=> $stable(tgt_q));
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// Self-checking bench for branch_redirect: vector table, directed multi-cycle
// sequences and randomized traffic against a behavioural redirect model.
module tb_branch_redirect;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] rj;
    logic [31:0] rd;
    logic [31:0] offs;
    logic        allow;
    logic [32:0] jbr_bus;
    logic [31:0] link;
    logic        link_we;
    logic        busy;
    logic        flush;
    logic        ade;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: is a redirect outstanding, its target, pending ade.
    bit          m_known = 0;
    bit          m_pend  = 0;
    logic [31:0] m_tgt   = '0;
    bit          m_ade   = 0;

    branch_redirect dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .ex_valid_i            (valid),
        .ex_br_op_i            (op),
        .ex_pc_i               (pc),
        .ex_rj_i               (rj),
        .ex_rd_i               (rd),
        .ex_offs_i             (offs),
        .ctl_if_allow_nxt_pc_i (allow),
        .jbr_bus_o             (jbr_bus),
        .ex_link_o             (link),
        .ex_link_we_o          (link_we),
        .ex_br_busy_o          (busy),
        .ex_flush_o            (flush),
        .ex_ade_o              (ade)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_cond(input logic [3:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
        case (o)
            4'd1: return a == b;
            4'd2: return a != b;
            4'd3: return int'(a) < int'(b);
            4'd4: return int'(a) >= int'(b);
            4'd5: return longint'(a) < longint'(b);
            4'd6: return longint'(a) >= longint'(b);
            4'd7, 4'd8, 4'd9: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [3:0] o, input logic [31:0] p,
                                               input logic [31:0] a, input logic [31:0] f);
        longint s;
        s = (o == 4'd9) ? longint'(a) + longint'(f) : longint'(p) + longint'(f);
        return s[31:0];
    endfunction

    task automatic drive(input logic r, input logic v, input logic [3:0] o,
                         input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] f, input logic al);
        rst = r; valid = v; op = o; pc = p; rj = a; rd = b; offs = f; allow = al;
    endtask

    task automatic drive_idle(input logic al);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, al);
    endtask

    // One clock: compare all outputs with the model mid-cycle, then advance it.
    task automatic tick();
        logic [32:0] e_jbr;
        bit          e_busy;
        bit          fire;
        logic [31:0] t;
        bit          n_pend;
        logic [31:0] n_tgt;
        bit          n_ade;
        @(negedge clk);
        e_jbr  = m_pend ? {1'b1, m_tgt} : 33'd0;
        e_busy = m_pend && !allow;
        if (m_known) begin
            check("model_jbr_bus", jbr_bus, e_jbr);
            check("model_busy", busy, e_busy);
            check("model_flush", flush, m_pend && allow);
            check("model_ade", ade, m_ade);
            check("model_link", link, pc + 32'd4);
            check("model_link_we", link_we, valid && (op == 4'd8 || op == 4'd9));
        end
        t    = ref_target(op, pc, rj, offs);
        fire = valid && ref_cond(op, rj, rd) && !e_busy;
        if (rst) begin
            n_pend = 0; n_tgt = '0; n_ade = 0;
        end else begin
            n_ade = fire && (t % 4 != 0);
            if (fire && (t % 4 == 0)) begin
                n_pend = 1; n_tgt = t;
            end else begin
                n_pend = m_pend && !allow; n_tgt = m_tgt;
            end
        end
        @(posedge clk);
        #1;
        m_pend  = n_pend;
        m_tgt   = n_tgt;
        m_ade   = n_ade;
        m_known = m_known || rst;
    endtask

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] pc;
        logic [31:0] rj;
        logic [31:0] rd;
        logic [31:0] offs;
        logic [32:0] exp_jbr;
        logic        exp_ade;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic v, input logic [3:0] o, input logic [31:0] p,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] f, input logic [32:0] ej, input logic ea);
        vec_t x;
        x.valid = v; x.op = o; x.pc = p; x.rj = a; x.rd = b; x.offs = f;
        x.exp_jbr = ej; x.exp_ade = ea;
        return x;
    endfunction

    initial begin
        vecs[0]  = mk(1, 4'd1, 32'h1c000000, 32'h5, 32'h5, 32'h40, 33'h1_1c000040, 0);
        vecs[1]  = mk(1, 4'd1, 32'h1c000000, 32'h5, 32'h6, 32'h40, 33'h0, 0);
        vecs[2]  = mk(1, 4'd2, 32'h1000, 32'h5, 32'h6, 32'hFFFFFFF0, 33'h1_00000FF0, 0);
        vecs[3]  = mk(1, 4'd3, 32'h2000, 32'hFFFFFFFF, 32'h1, 32'h20, 33'h1_00002020, 0);
        vecs[4]  = mk(1, 4'd5, 32'h2000, 32'hFFFFFFFF, 32'h1, 32'h20, 33'h0, 0);
        vecs[5]  = mk(1, 4'd4, 32'h3000, 32'h1, 32'hFFFFFFFF, 32'h8, 33'h1_00003008, 0);
        vecs[6]  = mk(1, 4'd6, 32'h3000, 32'h1, 32'hFFFFFFFF, 32'h8, 33'h0, 0);
        vecs[7]  = mk(1, 4'd7, 32'h100, 32'h0, 32'h0, 32'h10, 33'h1_00000110, 0);
        vecs[8]  = mk(1, 4'd9, 32'h400, 32'h1c000002, 32'h0, 32'h0, 33'h0, 1);
        vecs[9]  = mk(1, 4'd12, 32'h100, 32'h3, 32'h3, 32'h10, 33'h0, 0);
        vecs[10] = mk(1, 4'd0, 32'h100, 32'h3, 32'h3, 32'h10, 33'h0, 0);
        vecs[11] = mk(0, 4'd7, 32'h100, 32'h0, 32'h0, 32'h10, 33'h0, 0);
        vecs[12] = mk(1, 4'd7, 32'hFFFFFFF0, 32'h0, 32'h0, 32'h20, 33'h1_00000010, 0);
        vecs[13] = mk(1, 4'd9, 32'h500, 32'h1c001000, 32'h0, 32'h8, 33'h1_1c001008, 0);
        vecs[14] = mk(1, 4'd8, 32'h200, 32'h0, 32'h0, 32'hFFFFFFFC, 33'h1_000001FC, 0);
        vecs[15] = mk(1, 4'd7, 32'h100, 32'h0, 32'h0, 32'h2, 33'h0, 1);
        vecs[16] = mk(1, 4'd4, 32'h600, 32'h7, 32'h7, 32'h4, 33'h1_00000604, 0);
        vecs[17] = mk(1, 4'd5, 32'h700, 32'h1, 32'hFFFFFFFF, 32'hC, 33'h1_0000070C, 0);

        drive(1'b1, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        tick();
        drive_idle(1'b0);
        #1;
        check("reset_jbr_bus", jbr_bus, 33'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_flush", flush, 1'b0);
        check("reset_ade", ade, 1'b0);
        tick();

        // Vector table: each branch presented from IDLE with fetch always accepting.
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, vecs[i].valid, vecs[i].op, vecs[i].pc, vecs[i].rj, vecs[i].rd,
                  vecs[i].offs, 1'b1);
            #1;
            check($sformatf("vec%0d_link", i), link, vecs[i].pc + 32'd4);
            tick();
            drive_idle(1'b1);
            #1;
            check($sformatf("vec%0d_jbr_bus", i), jbr_bus, vecs[i].exp_jbr);
            check($sformatf("vec%0d_ade", i), ade, vecs[i].exp_ade);
            check($sformatf("vec%0d_flush", i), flush, vecs[i].exp_jbr[32]);
            tick();
            check($sformatf("vec%0d_idle", i), jbr_bus, 33'h0);
            check($sformatf("vec%0d_ade_clr", i), ade, 1'b0);
        end

        // Fetch stall: JIRL held three cycles while a BNE is presented and ignored.
        drive(1'b0, 1'b1, 4'd9, 32'h800, 32'h1c001000, 32'h0, 32'h8, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 4'd2, 32'h5000, 32'h1, 32'h2, 32'h100, 1'b0);
            #1;
            check("stall_jbr_bus", jbr_bus, 33'h1_1c001008);
            check("stall_busy", busy, 1'b1);
            check("stall_flush", flush, 1'b0);
            tick();
        end
        drive_idle(1'b1);
        #1;
        check("stall_release_jbr", jbr_bus, 33'h1_1c001008);
        check("stall_release_flush", flush, 1'b1);
        tick();
        check("stall_after_jbr", jbr_bus, 33'h0);
        check("stall_after_flush", flush, 1'b0);

        // Misaligned JIRL target: one-cycle ade, never a redirect.
        drive(1'b0, 1'b1, 4'd9, 32'h900, 32'h1c000002, 32'h0, 32'h0, 1'b1);
        tick();
        drive_idle(1'b1);
        #1;
        check("ade_set", ade, 1'b1);
        check("ade_no_redirect", jbr_bus, 33'h0);
        tick();
        check("ade_one_cycle", ade, 1'b0);

        // Back-to-back: BL fires on the edge that consumes the B redirect.
        drive(1'b0, 1'b1, 4'd7, 32'h100, 32'h0, 32'h0, 32'h10, 1'b0);
        tick();
        drive(1'b0, 1'b1, 4'd8, 32'h200, 32'h0, 32'h0, 32'hFFFFFFFC, 1'b1);
        #1;
        check("b2b_first_jbr", jbr_bus, 33'h1_00000110);
        check("b2b_flush", flush, 1'b1);
        check("b2b_link", link, 32'h204);
        check("b2b_link_we", link_we, 1'b1);
        tick();
        drive_idle(1'b1);
        #1;
        check("b2b_second_jbr", jbr_bus, 33'h1_000001FC);
        check("b2b_second_flush", flush, 1'b1);
        tick();
        check("b2b_idle", jbr_bus, 33'h0);

        // Reset while a redirect is pending drops it.
        drive(1'b0, 1'b1, 4'd7, 32'h100, 32'h0, 32'h0, 32'h10, 1'b0);
        tick();
        check("rst_mid_pending_set", jbr_bus, 33'h1_00000110);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        drive_idle(1'b0);
        #1;
        check("rst_mid_jbr", jbr_bus, 33'h0);
        check("rst_mid_busy", busy, 1'b0);
        tick();

        // Randomized traffic; branches are withheld while the model says busy.
        for (int n = 0; n < 600; n++) begin
            logic        r_v;
            logic        r_al;
            logic [3:0]  r_op;
            logic [31:0] r_pc;
            logic [31:0] r_rj;
            logic [31:0] r_rd;
            logic [31:0] r_off;
            r_al  = ($urandom_range(0, 3) != 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_op  = 4'($urandom_range(0, 15));
            r_pc  = $urandom & 32'hFFFF_FFFC;
            r_rj  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            r_rd  = ($urandom_range(0, 2) == 0) ? r_rj : $urandom;
            r_off = ($urandom_range(0, 7) == 0) ? $urandom : (($urandom & 32'h3FFF) << 2);
            if (m_pend && !r_al) r_v = 1'b0;
            drive(($urandom_range(0, 99) == 0), r_v, r_op, r_pc, r_rj, r_rd, r_off, r_al);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
